// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency-meter block and its neighbours.
// Provides the default counter width, the frequency word type and a ceil(log2) sizing helper.
package freq_meter_pkg;

  localparam int DEF_CNT_W = 24;

  typedef logic [DEF_CNT_W-1:0] freq_word_t;

  localparam freq_word_t CNT_MAX = '1;

  // ceil(log2(v)), never below 1 so that a counter always has at least one bit
  function automatic int clog2(input longint unsigned v);
    longint unsigned x;
    int r;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input, followed by a history flop.
// rise is high for one cycle when the synchronised level goes from 0 to 1.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      hist <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~hist;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronised rising edges of sig_in over GATE_CYCLES
// clocks and publishes the count as a held word with a one-cycle valid strobe.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             sat
);

  localparam int GATE_W = clog2(64'(GATE_CYCLES));
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  if (SYNC_STAGES < 2 || GATE_CYCLES < 2 || CLK_HZ == 0) begin : g_bad_param
    $error("freq_meter: illegal parameter value");
  end

  logic              rise;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              sat_flag;
  logic              gate_end;
  logic [CNT_W-1:0]  cnt_next;
  logic              sat_next;

  sync_edge_det #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sig_in),
    .rise (rise)
  );

  assign gate_end = (gate_cnt == GATE_LAST);

  // The count including this cycle's detect; it sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_next = edge_cnt;
    if (rise && !(&edge_cnt)) begin
      cnt_next = edge_cnt + 1'b1;
    end
    sat_next = sat_flag | (&cnt_next);
  end

  // en has priority over gate_end, so a window interrupted by en low never publishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat_flag   <= 1'b0;
      freq_out   <= '0;
      freq_valid <= 1'b0;
      sat        <= 1'b0;
    end else if (!en) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat_flag   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= gate_end;
      if (gate_end) begin
        gate_cnt <= '0;
        freq_out <= cnt_next;
        sat      <= sat_next;
        edge_cnt <= '0;
        sat_flag <= 1'b0;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_cnt <= cnt_next;
        sat_flag <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Randomised bench for freq_meter: a 24-bit and a 4-bit instance share all inputs and are
// checked against a model that bins each driven rising edge into the window that counts it.
module tb_freq_meter;

  localparam int GATE = 1000;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sig_in = 1'b0;
  logic [23:0] f24;
  logic        v24, s24;
  logic [3:0]  f4;
  logic        v4, s4;

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(24), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .freq_out(f24), .freq_valid(v24), .sat(s24)
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .freq_out(f4), .freq_valid(v4), .sat(s4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Model: each driven 0->1 of sig_in is counted at a known clock edge; a window is an edge range.
  int det_q[$];
  bit act = 1'b0;
  int lo = 0, hi = 0;
  logic prev_s = 1'b0, prev_e = 1'b0;
  int exp_f24 = 0, exp_s24 = 0, exp_f4 = 0, exp_s4 = 0;
  int ph = 0;

  function automatic logic tone(input int per, input int hw);
    return (per > 0) && ((ph % per) < hw);
  endfunction

  task automatic publish(input int n);
    int c;
    c = 0;
    foreach (det_q[i]) if (det_q[i] >= lo && det_q[i] <= hi) c++;
    while (det_q.size() > 0 && det_q[0] <= hi) void'(det_q.pop_front());
    exp_f24 = c;
    exp_s24 = (c >= (1 << 24) - 1) ? 1 : 0;
    exp_f4  = (c > 15) ? 15 : c;
    exp_s4  = (c >= 15) ? 1 : 0;
    $display("window end @%0d: edges=%0d freq24=%0d freq4=%0d sat4=%0d", n, c, f24, f4, s4);
    check("freq24", 32'(f24), 32'(exp_f24));
    check("sat24", 32'(s24), 32'(exp_s24));
    check("freq4", 32'(f4), 32'(exp_f4));
    check("sat4", 32'(s4), 32'(exp_s4));
    lo = hi + 1;
    hi = hi + GATE;
  endtask

  // One clock: check outputs after edge n, optionally pulse reset, then drive for edge n+1.
  task automatic tick(input logic s, input logic e, input bit rp);
    int n;
    bit ev;
    @(negedge clk);
    n = cyc;
    ev = act && (n == hi);
    check("valid24", 32'(v24), 32'(ev));
    check("valid4", 32'(v4), 32'(ev));
    if (ev) publish(n);
    if (n % 128 == 0) begin
      check("hold24", 32'(f24), 32'(exp_f24));
      check("hold4", 32'(f4), 32'(exp_f4));
      check("holdsat4", 32'(s4), 32'(exp_s4));
    end
    if (rp) begin
      rst_n = 1'b0;
      #2;
      check("rst_f24", 32'(f24), 32'd0);
      check("rst_v24", 32'(v24), 32'd0);
      check("rst_f4", 32'(f4), 32'd0);
      check("rst_s4", 32'(s4), 32'd0);
      #1;
      rst_n = 1'b1;
      det_q.delete();
      act = 1'b0;
      prev_s = 1'b0;
      prev_e = 1'b0;
      exp_f24 = 0; exp_s24 = 0; exp_f4 = 0; exp_s4 = 0;
    end
    sig_in = s;
    en = e;
    if (s && !prev_s) det_q.push_back(n + 1 + SYNC);
    if (e && !prev_e) begin
      act = 1'b1;
      lo = n + 1;
      hi = n + GATE;
    end
    if (!e) act = 1'b0;
    prev_s = s;
    prev_e = e;
    ph++;
  endtask

  task automatic run(input int len, input int per, input int hw, input logic e);
    for (int k = 0; k < len; k++) tick(tone(per, hw), e, 1'b0);
  endtask

  initial begin
    int per, hw, len;
    // Reset and idle window
    repeat (5) begin
      @(negedge clk);
      check("rstq_f24", 32'(f24), 32'd0);
      check("rstq_v24", 32'(v24), 32'd0);
      check("rstq_s4", 32'(s4), 32'd0);
    end
    rst_n = 1'b1;
    run(1005, 0, 0, 1'b1);
    // Steady tone, period 10
    run(3000, 10, 5, 1'b1);
    // Edge detects on the last cycle of one window and early in the next
    run(1000, 0, 0, 1'b1);
    for (int k = 0; k < 2000 && (hi - (cyc + 1)) != 3; k++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    run(1005, 0, 0, 1'b1);
    // Saturation of the narrow instance, then an idle window
    run(2000, 4, 2, 1'b1);
    run(1100, 0, 0, 1'b1);
    // Enable drop mid-window with a period-5 tone
    for (int k = 0; k < 2000 && ((cyc + 1) - lo) < 500; k++) tick(tone(5, 2), 1'b1, 1'b0);
    run(20, 5, 2, 1'b0);
    run(1010, 5, 2, 1'b1);
    // Enable low exactly on the terminal cycle of a window
    for (int k = 0; k < 2000 && (cyc + 1) != hi; k++) tick(tone(5, 2), 1'b1, 1'b0);
    run(3, 5, 2, 1'b0);
    run(1010, 5, 2, 1'b1);
    // Asynchronous reset mid-window with the tone running
    for (int k = 0; k < 2000 && ((cyc + 1) - lo) < 700; k++) tick(tone(10, 5), 1'b1, 1'b0);
    tick(tone(10, 5), 1'b1, 1'b1);
    run(1010, 10, 5, 1'b1);
    // Random tones and enable patterns
    for (int seg = 0; seg < 8; seg++) begin
      per = $urandom_range(4, 30);
      hw  = $urandom_range(2, per - 2);
      len = $urandom_range(300, 1500);
      run(len, per, hw, ($urandom_range(0, 4) != 0));
    end
    run(1010, 7, 3, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
